// File: rtl/fsm_seq_tx.sv
// fsm_seq_tx: sends the unlock header 0x81, 0x42, 0x24, 0x18 on a valid/ready
// byte stream, followed by a programmable number of 0x1C keep-alive bytes.
//
// Handshake: a byte moves on a rising edge where out_vld=1 and out_rdy=1.
// While out_vld=1 and out_rdy=0, out_val, out_vld and the internal state all
// hold. out_vld never drops without a transfer, except on abort or reset.
module fsm_seq_tx #(
  parameter int unsigned KEEP_W    = 8,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [KEEP_W-1:0] keep_len,
  input  logic              abort,
  output logic [7:0]        out_val,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_H0   = 3'd1,
    S_H1   = 3'd2,
    S_H2   = 3'd3,
    S_H3   = 3'd4,
    S_KEEP = 3'd5
  } state_t;

  localparam logic [7:0] HDR0_BYTE = 8'h81;
  localparam logic [7:0] HDR1_BYTE = 8'h42;
  localparam logic [7:0] HDR2_BYTE = 8'h24;
  localparam logic [7:0] HDR3_BYTE = 8'h18;
  localparam logic [7:0] KEEP_BYTE = 8'h1C;

  localparam logic [KEEP_W-1:0] KCNT_ZERO = '0;
  localparam logic [KEEP_W-1:0] KCNT_ONE  = {{(KEEP_W-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [KEEP_W-1:0] kcnt, kcnt_n;
  logic [7:0]        out_val_n;
  logic              out_vld_n;
  logic              done_n;
  logic              xfer;

  // Byte presented on the stream in a given state.
  function automatic logic [7:0] state_byte(input state_t s);
    logic [7:0] b;
    b = IDLE_BYTE;
    case (s)
      S_H0:    b = HDR0_BYTE;
      S_H1:    b = HDR1_BYTE;
      S_H2:    b = HDR2_BYTE;
      S_H3:    b = HDR3_BYTE;
      S_KEEP:  b = KEEP_BYTE;
      default: b = IDLE_BYTE;
    endcase
    return b;
  endfunction

  // out_vld is a register equal to (state != IDLE), so it qualifies transfers.
  assign xfer = out_vld & out_rdy;

  // Next state, keep-alive counter and done pulse.
  always_comb begin
    state_n = state;
    kcnt_n  = kcnt;
    done_n  = 1'b0;

    case (state)
      S_IDLE: begin
        // abort in IDLE wins over start: nothing is launched.
        if (start && !abort) begin
          state_n = S_H0;
          kcnt_n  = keep_len;
        end
      end
      S_H0: if (xfer) state_n = S_H1;
      S_H1: if (xfer) state_n = S_H2;
      S_H2: if (xfer) state_n = S_H3;
      S_H3: begin
        if (xfer) begin
          if (kcnt == KCNT_ZERO) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = S_KEEP;
          end
        end
      end
      S_KEEP: begin
        // kcnt is nonzero whenever KEEP is entered; the guard keeps it from wrapping.
        if (xfer && (kcnt != KCNT_ZERO)) begin
          kcnt_n = kcnt - KCNT_ONE;
          if (kcnt == KCNT_ONE) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        kcnt_n  = KCNT_ZERO;
      end
    endcase

    // abort outranks a simultaneous transfer and suppresses done.
    if (abort && (state != S_IDLE)) begin
      state_n = S_IDLE;
      kcnt_n  = KCNT_ZERO;
      done_n  = 1'b0;
    end

    // Outputs are registered from the next state so they line up with it.
    out_val_n = state_byte(state_n);
    out_vld_n = (state_n != S_IDLE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      kcnt    <= KCNT_ZERO;
      out_val <= IDLE_BYTE;
      out_vld <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      kcnt    <= kcnt_n;
      out_val <= out_val_n;
      out_vld <= out_vld_n;
      done    <= done_n;
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_fsm_seq_tx.sv
// tb_fsm_seq_tx: directed and randomized stimulus for fsm_seq_tx, checked
// against a byte-queue reference model of the transmit sequence.
module tb_fsm_seq_tx;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [7:0] keep_len;
  logic       abort;
  logic [7:0] out_val;
  logic       out_vld;
  logic       out_rdy;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes still to be sent (head is on the bus), plus flags.
  logic [7:0] exp_q[$];
  logic       m_busy;
  logic       m_done;

  fsm_seq_tx #(.KEEP_W(8), .IDLE_BYTE(8'h00)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .keep_len  (keep_len),
    .abort     (abort),
    .out_val   (out_val),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] exp_val;
    exp_val = (m_busy && exp_q.size() > 0) ? exp_q[0] : 8'h00;
    check({tag, ".out_vld"}, {7'd0, out_vld}, {7'd0, m_busy});
    check({tag, ".out_val"}, out_val, exp_val);
    check({tag, ".busy"},    {7'd0, busy},    {7'd0, m_busy});
    check({tag, ".done"},    {7'd0, done},    {7'd0, m_done});
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_busy = 1'b0;
    m_done = 1'b0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input logic s, input logic a, input logic r, input logic [7:0] k);
    m_done = 1'b0;
    if (!m_busy) begin
      if (s && !a) begin
        exp_q = '{8'h81, 8'h42, 8'h24, 8'h18};
        for (int i = 0; i < int'(k); i++) exp_q.push_back(8'h1C);
        m_busy = 1'b1;
      end
    end else if (a) begin
      exp_q.delete();
      m_busy = 1'b0;
    end else if (r) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  // Drive inputs, clock one edge, then sample just after it.
  task automatic step(input string tag, input logic s, input logic a, input logic r,
                      input logic [7:0] k);
    start    = s;
    abort    = a;
    out_rdy  = r;
    keep_len = k;
    model_edge(s, a, r, k);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rstn     = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    out_rdy  = 1'b0;
    keep_len = 8'd0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    // keep_len=0, always ready: 4 header bytes then done
    step("k0", 1'b1, 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 5; i++) step("k0", 1'b0, 1'b0, 1'b1, 8'd0);

    // keep_len=3, always ready; keep_len wiggled while busy has no effect
    step("k3", 1'b1, 1'b0, 1'b1, 8'd3);
    for (int i = 0; i < 8; i++) step("k3", 1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)));

    // keep_len=2, random ready stalls
    step("k2rdy", 1'b1, 1'b0, 1'b0, 8'd2);
    for (int i = 0; i < 40; i++) step("k2rdy", 1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'd2);
    for (int i = 0; i < 8; i++) step("k2drain", 1'b0, 1'b0, 1'b1, 8'd2);

    // abort while in H2 and stalled, then restart
    step("abort", 1'b1, 1'b0, 1'b1, 8'd4);
    step("abort", 1'b0, 1'b0, 1'b1, 8'd4);
    step("abort", 1'b0, 1'b0, 1'b1, 8'd4);
    step("abort_stall", 1'b0, 1'b0, 1'b0, 8'd4);
    step("abort_h2", 1'b0, 1'b1, 1'b0, 8'd4);
    step("abort_restart", 1'b1, 1'b0, 1'b0, 8'd4);
    step("abort_xfer", 1'b0, 1'b1, 1'b1, 8'd4);
    step("abort_idle", 1'b0, 1'b1, 1'b1, 8'd4);
    step("abort_vs_start", 1'b1, 1'b1, 1'b1, 8'd4);
    step("idle_hold", 1'b0, 1'b0, 1'b1, 8'd4);

    // Asynchronous reset mid-KEEP
    step("arst", 1'b1, 1'b0, 1'b1, 8'd5);
    for (int i = 0; i < 5; i++) step("arst", 1'b0, 1'b0, 1'b1, 8'd5);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs("arst_now");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) step("arst_after", 1'b0, 1'b0, 1'b1, 8'd5);

    // start held high, keep_len=1: repeated sequences with one idle/done gap
    for (int i = 0; i < 20; i++) step("held", 1'b1, 1'b0, 1'b1, 8'd1);
    for (int i = 0; i < 8; i++) step("held_drain", 1'b0, 1'b0, 1'b1, 8'd1);

    // Random mix of start, abort, ready and keep_len
    for (int i = 0; i < 400; i++) begin
      step("rand",
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
